// File: rtl/rs_station_ooo_pkg.sv
// Shared widths, the "no tag" constant and the ALU opcode encodings
// used by the reservation station and its neighbours.
package rs_station_ooo_pkg;

  localparam int ID_W_DEF = 5;
  localparam int XLEN_DEF = 32;
  localparam int OP_W_DEF = 6;

  // ROB tag 0 means "operand already holds its value".
  localparam int TAG_NONE = 0;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9
  } alu_op_e;

endpackage

// File: rtl/rs_station_ooo_if.sv
// Issuer-side allocate bus, result broadcast channels and ALU-side issue bus.
// master = issuer/CDB/ALU environment, slave = reservation station.
interface rs_station_ooo_if
  import rs_station_ooo_pkg::*;
#(
  parameter int NUM_CDB = 2,
  parameter int ID_W    = ID_W_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int OP_W    = OP_W_DEF
) ();

  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [ID_W-1:0]         alloc_dest;
  logic [OP_W-1:0]         alloc_op;
  logic [ID_W-1:0]         alloc_qj;
  logic [ID_W-1:0]         alloc_qk;
  logic [XLEN-1:0]         alloc_vj;
  logic [XLEN-1:0]         alloc_vk;
  logic [XLEN-1:0]         alloc_imm;
  logic [XLEN-1:0]         alloc_pc;

  logic [NUM_CDB-1:0]      cdb_valid;
  logic [NUM_CDB*ID_W-1:0] cdb_dest;
  logic [NUM_CDB*XLEN-1:0] cdb_value;

  logic                    issue_valid;
  logic                    issue_ready;
  logic [OP_W-1:0]         issue_op;
  logic [ID_W-1:0]         issue_dest;
  logic [XLEN-1:0]         issue_vj;
  logic [XLEN-1:0]         issue_vk;
  logic [XLEN-1:0]         issue_imm;
  logic [XLEN-1:0]         issue_pc;

  modport master (
    output alloc_valid, alloc_dest, alloc_op, alloc_qj, alloc_qk,
           alloc_vj, alloc_vk, alloc_imm, alloc_pc,
    input  alloc_ready,
    output cdb_valid, cdb_dest, cdb_value,
    input  issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
           issue_imm, issue_pc,
    output issue_ready
  );

  modport slave (
    input  alloc_valid, alloc_dest, alloc_op, alloc_qj, alloc_qk,
           alloc_vj, alloc_vk, alloc_imm, alloc_pc,
    output alloc_ready,
    input  cdb_valid, cdb_dest, cdb_value,
    output issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
           issue_imm, issue_pc,
    input  issue_ready
  );

endinterface

// File: rtl/rs_station_ooo_age_matrix.sv
// Age matrix for the reservation station: older[i][j]=1 means entry i
// was allocated before entry j. Grants the oldest requesting entry.
module rs_age_matrix #(
  parameter int  DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic             free_en,
  input  logic [IDX_W-1:0] free_idx,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] older     [DEPTH];
  logic [DEPTH-1:0] older_nxt [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] occ_nxt;

  // Next matrix: a new entry is younger than every occupied one; a freed
  // entry drops out of both its row and its column.
  always_comb begin
    occ_nxt = occ;
    for (int i = 0; i < DEPTH; i++) older_nxt[i] = older[i];
    if (alloc_en) begin
      for (int i = 0; i < DEPTH; i++) older_nxt[i][alloc_idx] = occ[i];
      older_nxt[alloc_idx] = '0;
      occ_nxt[alloc_idx]   = 1'b1;
    end
    if (free_en) begin
      for (int i = 0; i < DEPTH; i++) older_nxt[i][free_idx] = 1'b0;
      older_nxt[free_idx] = '0;
      occ_nxt[free_idx]   = 1'b0;
    end
  end

  // Matrix state, frozen while en is low, wiped on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (en) begin
      if (clr) begin
        occ <= '0;
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
        occ <= occ_nxt;
        for (int i = 0; i < DEPTH; i++) older[i] <= older_nxt[i];
      end
    end
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_station_ooo.sv
// Out-of-order reservation station: DEPTH waiting entries snooping NUM_CDB
// broadcast channels, oldest-ready select into a registered issue stage.
module rs_station_ooo
  import rs_station_ooo_pkg::*;
#(
  parameter int  DEPTH        = 16,
  parameter int  NUM_CDB      = 2,
  parameter int  ID_W         = ID_W_DEF,
  parameter int  XLEN         = XLEN_DEF,
  parameter int  OP_W         = OP_W_DEF,
  parameter int  AFULL_MARGIN = 1,
  localparam int IDX_W        = $clog2(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  rs_station_ooo_if.slave   bus,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              almost_full
);

  // Entry array (stage p0)
  logic [DEPTH-1:0] busy_p0;
  logic [ID_W-1:0]  dest_p0 [DEPTH];
  logic [OP_W-1:0]  op_p0   [DEPTH];
  logic [ID_W-1:0]  qj_p0   [DEPTH];
  logic [ID_W-1:0]  qk_p0   [DEPTH];
  logic [XLEN-1:0]  vj_p0   [DEPTH];
  logic [XLEN-1:0]  vk_p0   [DEPTH];
  logic [XLEN-1:0]  imm_p0  [DEPTH];
  logic [XLEN-1:0]  pc_p0   [DEPTH];

  // Issue register (stage p1)
  logic             vld_p1;
  logic [OP_W-1:0]  op_p1;
  logic [ID_W-1:0]  dest_p1;
  logic [XLEN-1:0]  vj_p1, vk_p1, imm_p1, pc_p1;

  logic [DEPTH-1:0] ready_vec, grant;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             alloc_fire, load_fire, dup_tag;
  logic [XLEN:0]    wj_lk [DEPTH];
  logic [XLEN:0]    wk_lk [DEPTH];
  logic [XLEN:0]    aj_lk, ak_lk;

  // Tag lookup across the broadcast channels; {hit, value}. The lowest
  // channel index wins, and tag 0 never matches.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ID_W-1:0]         tag,
    input logic [NUM_CDB-1:0]      cv,
    input logic [NUM_CDB*ID_W-1:0] cd,
    input logic [NUM_CDB*XLEN-1:0] cval
  );
    logic [XLEN:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cv[c] && cd[c*ID_W +: ID_W] == tag && tag != ID_W'(TAG_NONE))
        r = {1'b1, cval[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  assign full            = (count == CNT_W'(DEPTH));
  assign almost_full     = (count >= CNT_W'(DEPTH - AFULL_MARGIN));
  assign bus.alloc_ready = rdy && !flush && !full;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign load_fire       = rdy && !flush && (|ready_vec) && (!vld_p1 || bus.issue_ready);

  // Wakeup lookups, readiness from registered state, lowest free / granted slot.
  always_comb begin
    aj_lk    = cdb_lookup(bus.alloc_qj, bus.cdb_valid, bus.cdb_dest, bus.cdb_value);
    ak_lk    = cdb_lookup(bus.alloc_qk, bus.cdb_valid, bus.cdb_dest, bus.cdb_value);
    free_idx = '0;
    sel_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wj_lk[i]     = cdb_lookup(qj_p0[i], bus.cdb_valid, bus.cdb_dest, bus.cdb_value);
      wk_lk[i]     = cdb_lookup(qk_p0[i], bus.cdb_valid, bus.cdb_dest, bus.cdb_value);
      ready_vec[i] = busy_p0[i] && qj_p0[i] == ID_W'(TAG_NONE) && qk_p0[i] == ID_W'(TAG_NONE);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_p0[i]) free_idx = IDX_W'(i);
      if (grant[i])    sel_idx  = IDX_W'(i);
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .clr       (flush),
    .alloc_en  (alloc_fire),
    .alloc_idx (free_idx),
    .free_en   (load_fire),
    .free_idx  (sel_idx),
    .req       (ready_vec),
    .grant     (grant)
  );

  // Entry payload: operand capture from the CDB and writes of new entries.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_p0[i] && wj_lk[i][XLEN]) begin
          qj_p0[i] <= '0;
          vj_p0[i] <= wj_lk[i][XLEN-1:0];
        end
        if (busy_p0[i] && wk_lk[i][XLEN]) begin
          qk_p0[i] <= '0;
          vk_p0[i] <= wk_lk[i][XLEN-1:0];
        end
      end
      if (alloc_fire) begin
        dest_p0[free_idx] <= bus.alloc_dest;
        op_p0[free_idx]   <= bus.alloc_op;
        imm_p0[free_idx]  <= bus.alloc_imm;
        pc_p0[free_idx]   <= bus.alloc_pc;
        qj_p0[free_idx]   <= aj_lk[XLEN] ? '0 : bus.alloc_qj;
        qk_p0[free_idx]   <= ak_lk[XLEN] ? '0 : bus.alloc_qk;
        vj_p0[free_idx]   <= aj_lk[XLEN] ? aj_lk[XLEN-1:0] : bus.alloc_vj;
        vk_p0[free_idx]   <= ak_lk[XLEN] ? ak_lk[XLEN-1:0] : bus.alloc_vk;
      end
    end
  end

  // Occupancy, count and the issue register; payload holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_p0 <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      dest_p1 <= '0;
      vj_p1   <= '0;
      vk_p1   <= '0;
      imm_p1  <= '0;
      pc_p1   <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy_p0 <= '0;
        count   <= '0;
        vld_p1  <= 1'b0;
      end else begin
        busy_p0 <= (busy_p0 | (alloc_fire ? (DEPTH'(1) << free_idx) : '0))
                   & ~(load_fire ? grant : '0);
        count   <= count + CNT_W'(alloc_fire) - CNT_W'(load_fire);
        if (load_fire) begin
          vld_p1  <= 1'b1;
          op_p1   <= op_p0[sel_idx];
          dest_p1 <= dest_p0[sel_idx];
          vj_p1   <= vj_p0[sel_idx];
          vk_p1   <= vk_p0[sel_idx];
          imm_p1  <= imm_p0[sel_idx];
          pc_p1   <= pc_p0[sel_idx];
        end else if (bus.issue_ready) begin
          vld_p1  <= 1'b0;
        end
      end
    end
  end

  assign bus.issue_valid = vld_p1;
  assign bus.issue_op    = op_p1;
  assign bus.issue_dest  = dest_p1;
  assign bus.issue_vj    = vj_p1;
  assign bus.issue_vk    = vk_p1;
  assign bus.issue_imm   = imm_p1;
  assign bus.issue_pc    = pc_p1;

  // Two channels broadcasting the same nonzero tag is an upstream bug.
  always_comb begin
    dup_tag = 1'b0;
    for (int a = 0; a < NUM_CDB; a++) begin
      for (int b = a + 1; b < NUM_CDB; b++) begin
        if (bus.cdb_valid[a] && bus.cdb_valid[b] &&
            bus.cdb_dest[a*ID_W +: ID_W] == bus.cdb_dest[b*ID_W +: ID_W] &&
            bus.cdb_dest[a*ID_W +: ID_W] != ID_W'(TAG_NONE))
          dup_tag = 1'b1;
      end
    end
  end

  a_no_dup_tag: assert property (@(posedge clk) disable iff (!rst) !(rdy && dup_tag));

endmodule

// File: tb/tb_rs_station_ooo.sv
// Directed bench for rs_station_ooo (DEPTH=4) with hand-computed expectations.
module tb_rs_station_ooo;
  import rs_station_ooo_pkg::*;

  localparam int DEPTH        = 4;
  localparam int NUM_CDB      = 2;
  localparam int ID_W         = ID_W_DEF;
  localparam int XLEN         = XLEN_DEF;
  localparam int OP_W         = OP_W_DEF;
  localparam int AFULL_MARGIN = 1;
  localparam int CNT_W        = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             almost_full;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  rs_station_ooo_if #(.NUM_CDB(NUM_CDB), .ID_W(ID_W), .XLEN(XLEN), .OP_W(OP_W)) bus ();

  rs_station_ooo #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ID_W(ID_W), .XLEN(XLEN),
    .OP_W(OP_W), .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .flush       (flush),
    .bus         (bus),
    .count       (count),
    .full        (full),
    .almost_full (almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = '0;
  endtask

  task automatic put(input int dest, input int qj, input int qk, input int vj, input int vk);
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = ID_W'(dest);
    bus.alloc_op    = OP_W'(dest);
    bus.alloc_qj    = ID_W'(qj);
    bus.alloc_qk    = ID_W'(qk);
    bus.alloc_vj    = XLEN'(vj);
    bus.alloc_vk    = XLEN'(vk);
    bus.alloc_imm   = XLEN'(dest * 16);
    bus.alloc_pc    = XLEN'(32'h1000 + dest * 4);
  endtask

  task automatic bcast(input int ch, input int tag, input int val);
    bus.cdb_valid[ch]                = 1'b1;
    bus.cdb_dest[ch*ID_W +: ID_W]    = ID_W'(tag);
    bus.cdb_value[ch*XLEN +: XLEN]   = XLEN'(val);
  endtask

  task automatic chk_iss(input string tag, input int dest, input int vj, input int vk);
    chk({tag, ".valid"}, 32'(bus.issue_valid), 1);
    chk({tag, ".dest"},  32'(bus.issue_dest), dest);
    chk({tag, ".vj"},    bus.issue_vj, vj);
    chk({tag, ".vk"},    bus.issue_vk, vk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.issue_ready = 1'b0;
    bus.cdb_dest = '0; bus.cdb_value = '0;
    put(0, 0, 0, 0, 0);
    idle();
    #22;
    chk("rst.count",       32'(count), 0);
    chk("rst.issue_valid", 32'(bus.issue_valid), 0);
    chk("rst.issue_dest",  32'(bus.issue_dest), 0);
    chk("rst.full",        32'(full), 0);
    chk("rst.afull",       32'(almost_full), 0);
    chk("rst.alloc_ready", 32'(bus.alloc_ready), 1);
    rst = 1'b1;
    tick();

    // Basic alloc -> issue, 2-edge latency
    bus.issue_ready = 1'b1;
    put(3, 0, 0, 5, 7);
    tick(); idle();
    chk("t1.count1", 32'(count), 1);
    chk("t1.not_yet", 32'(bus.issue_valid), 0);
    tick();
    chk_iss("t1", 3, 5, 7);
    chk("t1.op",  32'(bus.issue_op), 3);
    chk("t1.imm", bus.issue_imm, 32'h30);
    chk("t1.pc",  bus.issue_pc, 32'h100C);
    chk("t1.count0", 32'(count), 0);
    tick();
    chk("t1.drained", 32'(bus.issue_valid), 0);

    // Ready-first then oldest: 5, 4 (woken), 6
    bus.issue_ready = 1'b0;
    put(4, 9, 0, 32'hFF, 1); tick();
    put(5, 0, 0, 2, 3);      tick();
    put(6, 0, 0, 4, 5);      tick(); idle();
    chk_iss("t2.first", 5, 2, 3);
    chk("t2.count", 32'(count), 2);
    bcast(0, 9, 32'h11);     tick(); idle();
    chk("t2.held", 32'(bus.issue_dest), 5);
    bus.issue_ready = 1'b1;  tick();
    chk_iss("t2.second", 4, 32'h11, 1);
    tick();
    chk_iss("t2.third", 6, 4, 5);
    tick();
    chk("t2.empty", 32'(bus.issue_valid), 0);
    chk("t2.count0", 32'(count), 0);

    // Age beats index: older Q sits at entry 1, younger R reuses entry 0
    bus.issue_ready = 1'b0;
    put(7, 0, 0, 1, 0);   tick();
    put(8, 12, 0, 0, 6);  tick();
    put(9, 0, 0, 2, 0);   tick(); idle();
    bcast(0, 12, 32'h22); tick(); idle();
    chk("t2b.p", 32'(bus.issue_dest), 7);
    bus.issue_ready = 1'b1; tick();
    chk_iss("t2b.q", 8, 32'h22, 6);
    tick();
    chk_iss("t2b.r", 9, 2, 0);
    tick();
    chk("t2b.count0", 32'(count), 0);

    // Two-channel single-cycle wakeup, then allocate bypass
    bus.issue_ready = 1'b0;
    put(10, 2, 3, 0, 0);  tick(); idle();
    bcast(0, 2, 32'hA); bcast(1, 3, 32'hB); tick(); idle();
    chk("t3.wake_lat", 32'(bus.issue_valid), 0);
    tick();
    chk_iss("t3.wake", 10, 32'hA, 32'hB);
    bus.issue_ready = 1'b1;
    put(11, 7, 0, 32'h99, 5); bcast(1, 7, 32'h77); tick(); idle();
    chk("t3.gap", 32'(bus.issue_valid), 0);
    tick();
    chk_iss("t3.bypass", 11, 32'h77, 5);
    tick();
    chk("t3.count0", 32'(count), 0);

    // Backpressure: payload and count frozen while a younger entry wakes
    bus.issue_ready = 1'b0;
    put(12, 0, 0, 32'h12, 32'h34); tick();
    put(13, 14, 0, 0, 0);          tick(); idle();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) bcast(0, 14, 32'h33);
      tick(); idle();
      chk_iss("t4.hold", 12, 32'h12, 32'h34);
      chk("t4.count", 32'(count), 1);
    end
    bus.issue_ready = 1'b1; tick();
    chk_iss("t4.next", 13, 32'h33, 0);
    tick();
    chk("t4.count0", 32'(count), 0);

    // rdy=0 freezes everything
    put(15, 0, 0, 32'h55, 0); tick(); idle();
    rdy = 1'b0; #1;
    chk("t5.alloc_ready", 32'(bus.alloc_ready), 0);
    tick(); tick();
    chk("t5.frozen_valid", 32'(bus.issue_valid), 0);
    chk("t5.frozen_count", 32'(count), 1);
    rdy = 1'b1; tick();
    chk_iss("t5.resume", 15, 32'h55, 0);
    tick();
    chk("t5.count0", 32'(count), 0);

    // Full / almost_full with blocked entries, dropped extra alloc
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(16 + i, 20 + i, 0, 0, 0); tick();
      chk("t6.count", 32'(count), i + 1);
      chk("t6.afull", 32'(almost_full), (i + 1 >= 3) ? 1 : 0);
      chk("t6.full",  32'(full), (i + 1 == 4) ? 1 : 0);
    end
    put(30, 0, 0, 0, 0); #1;
    chk("t6.alloc_ready", 32'(bus.alloc_ready), 0);
    tick(); idle();
    chk("t6.dropped", 32'(count), 4);
    chk("t6.no_issue", 32'(bus.issue_valid), 0);
    bcast(0, 20, 32'h40); tick(); idle();
    tick();
    chk_iss("t6.wake", 16, 32'h40, 0);
    chk("t6.count3", 32'(count), 3);
    chk("t6.full_off", 32'(full), 0);

    // Flush with 3 busy entries and a pending issue
    flush = 1'b1; put(31, 0, 0, 0, 0); bcast(0, 21, 1); #1;
    chk("t7.alloc_ready", 32'(bus.alloc_ready), 0);
    tick(); idle(); flush = 1'b0;
    chk("t7.count", 32'(count), 0);
    chk("t7.valid", 32'(bus.issue_valid), 0);
    chk("t7.afull", 32'(almost_full), 0);
    bcast(0, 22, 2); tick(); idle(); tick();
    chk("t7.stale", 32'(bus.issue_valid), 0);
    chk("t7.count0", 32'(count), 0);

    // Asynchronous reset between edges
    put(24, 0, 0, 32'h66, 0); tick();
    put(25, 26, 0, 0, 0);     tick(); idle();
    chk("t8.pre_valid", 32'(bus.issue_valid), 1);
    chk("t8.pre_count", 32'(count), 1);
    #2 rst = 1'b0;
    #1;
    chk("t8.valid", 32'(bus.issue_valid), 0);
    chk("t8.count", 32'(count), 0);
    chk("t8.dest",  32'(bus.issue_dest), 0);
    chk("t8.vj",    bus.issue_vj, 0);
    #2 rst = 1'b1;
    tick(); tick();
    chk("t8.post_valid", 32'(bus.issue_valid), 0);
    chk("t8.post_count", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
